// File: rtl/seg_dec_pkg.sv
// Shared definitions for the multiplexed seven-segment scan decoder:
// FSM states, active-low glyph codes, special nibble codes and slot helpers.
package seg_dec_pkg;

    localparam int NUM_SLOTS = 4;

    // Nibble codes with special meaning on the decoded outputs
    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Anode pattern seen between digits while the scanner blanks the display
    localparam logic [3:0] ANODE_IDLE = 4'b1111;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g} with a as MSB
    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b1100000;
    localparam logic [6:0] GLYPH_C     = 7'b0110001;
    localparam logic [6:0] GLYPH_D     = 7'b1000010;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_F     = 7'b0111000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_COLLECT,
        ST_COMMIT
    } state_t;

    // Slot number selected by a single-low anode pattern (0 for anything else)
    function automatic logic [1:0] slot_index(input logic [3:0] anode);
        logic [1:0] idx;
        case (anode)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bundle of the sniffed display scan lines and the decoded frame outputs.
// master drives the scan lines, slave is the decoder.
interface seg_scan_decoder_if;

    logic [3:0] anode_active;
    logic [6:0] segments;
    logic       decimal;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] dp;
    logic       frame_valid;
    logic       seg_err;
    logic       anode_err;

    modport master (
        output anode_active, segments, decimal,
        input  digit0, digit1, digit2, digit3, dp, frame_valid, seg_err, anode_err
    );

    modport slave (
        input  anode_active, segments, decimal,
        output digit0, digit1, digit2, digit3, dp, frame_valid, seg_err, anode_err
    );

endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-to-nibble decoder for active-low seven-segment codes.
// Macro SEG_DEC_HEX_EN: when defined, the hex letters A,b,C,d,E,F decode to
// 4'hA-4'hF; otherwise they are treated as unrecognised (4'hE, invalid).
module seg_glyph_decode
    import seg_dec_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] nibble,
    output logic       invalid
);

    // Map each recognised glyph to its nibble; everything else is an error code
    always_comb begin
        nibble  = CODE_ERR;
        invalid = 1'b0;
        case (segments)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_BLANK: nibble = CODE_BLANK;
`ifdef SEG_DEC_HEX_EN
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
`endif
            default: begin
                nibble  = CODE_ERR;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four displayed digits from a sniffed, multiplexed
// seven-segment scan. Inputs are registered once, debounced by counting
// identical samples, then assembled slot 0..3 into a shadow frame that is
// committed atomically with a frame_valid pulse.
// Macro SEG_DEC_HEX_EN (in seg_glyph_decode) enables hex letter decoding.
module seg_scan_decoder
    import seg_dec_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,   // identical samples to accept a slot, 1..255
    parameter int DIGITS        = 4    // only 4 slots are supported
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_decoder_if.slave   bus
);

    localparam logic [7:0] SETTLE    = 8'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_SLOT = 2'(DIGITS - 1);

    // Registered samples and their one-cycle-older copy for change detection
    logic [3:0] anode_reg, anode_prev_reg;
    logic [6:0] seg_reg, seg_prev_reg;
    logic       dec_reg, dec_prev_reg;

    logic [7:0] cnt_reg, cnt_next;
    logic       dwell_done_reg, dwell_done_next;

    logic [3:0] slot_hit;
    logic       one_low, anode_idle, anode_illegal, anode_changed, sample_changed;
    logic       dwell_done_eff, accept, illegal_edge;
    logic [1:0] slot;
    logic [3:0] glyph_nibble;
    logic       glyph_invalid;

    state_t     state_reg, state_next;
    logic [1:0] expected_reg, expected_next;
    logic [3:0] shadow_digit_reg [DIGITS];
    logic [3:0] shadow_digit_next [DIGITS];
    logic [3:0] shadow_dp_reg, shadow_dp_next;
    logic [3:0] digit_reg [DIGITS];
    logic [3:0] digit_next [DIGITS];
    logic [3:0] dp_reg, dp_next;
    logic       frame_valid_reg, frame_valid_next;
    logic       seg_err_reg, seg_err_next;
    logic       anode_err_reg, anode_err_next;

    // Capture the raw scan lines once, and keep the previous sample
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_reg      <= ANODE_IDLE;
            seg_reg        <= GLYPH_BLANK;
            dec_reg        <= 1'b1;
            anode_prev_reg <= ANODE_IDLE;
            seg_prev_reg   <= GLYPH_BLANK;
            dec_prev_reg   <= 1'b1;
        end else begin
            anode_reg      <= bus.anode_active;
            seg_reg        <= bus.segments;
            dec_reg        <= bus.decimal;
            anode_prev_reg <= anode_reg;
            seg_prev_reg   <= seg_reg;
            dec_prev_reg   <= dec_reg;
        end
    end

    // One comparator per slot: slot k is selected when only bit k is low
    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_slot_hit
        assign slot_hit[gi] = (anode_reg == ~(4'b0001 << gi));
    end

    assign one_low        = |slot_hit;
    assign anode_idle     = (anode_reg == ANODE_IDLE);
    assign anode_illegal  = !anode_idle && !one_low;
    assign anode_changed  = (anode_reg != anode_prev_reg);
    assign sample_changed = ({anode_reg, seg_reg, dec_reg} !=
                             {anode_prev_reg, seg_prev_reg, dec_prev_reg});
    assign slot           = slot_index(anode_reg);
    // An illegal pattern is reported once when it appears, not every cycle
    assign illegal_edge   = anode_illegal && anode_changed;

    // Settle counter: blanking parks it at 0, any change restarts at 1.
    // A slot is accepted once per anode dwell, even if segments wobble later.
    always_comb begin
        if (anode_idle) begin
            cnt_next = 8'd0;
        end else if (sample_changed) begin
            cnt_next = 8'd1;
        end else if (cnt_reg != 8'hFF) begin
            cnt_next = cnt_reg + 8'd1;
        end else begin
            cnt_next = cnt_reg;
        end
        dwell_done_eff  = anode_changed ? 1'b0 : dwell_done_reg;
        // accept needs a single low anode bit, so it never coincides with an
        // illegal pattern; the error path always takes precedence below.
        accept          = one_low && (cnt_next == SETTLE) && !dwell_done_eff;
        dwell_done_next = anode_idle ? 1'b0 : (dwell_done_eff | accept);
    end

    // Settle counter and dwell flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= 8'd0;
            dwell_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            dwell_done_reg <= dwell_done_next;
        end
    end

    seg_glyph_decode u_glyph_decode (
        .segments (seg_reg),
        .nibble   (glyph_nibble),
        .invalid  (glyph_invalid)
    );

    // Frame assembly FSM: next state, shadow updates, commit and error pulses
    always_comb begin
        state_next        = state_reg;
        expected_next     = expected_reg;
        shadow_digit_next = shadow_digit_reg;
        shadow_dp_next    = shadow_dp_reg;
        digit_next        = digit_reg;
        dp_next           = dp_reg;
        frame_valid_next  = 1'b0;
        seg_err_next      = seg_err_reg;
        anode_err_next    = 1'b0;

        if (accept && glyph_invalid) begin
            seg_err_next = 1'b1;
        end

        case (state_reg)
            ST_SYNC: begin
                if (illegal_edge) begin
                    anode_err_next = 1'b1;
                end else if (accept && slot == 2'd0) begin
                    shadow_digit_next[0] = glyph_nibble;
                    shadow_dp_next[0]    = ~dec_reg;
                    expected_next        = 2'd1;
                    state_next           = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (illegal_edge) begin
                    anode_err_next = 1'b1;
                    state_next     = ST_SYNC;
                end else if (accept) begin
                    if (slot == expected_reg) begin
                        shadow_digit_next[slot] = glyph_nibble;
                        shadow_dp_next[slot]    = ~dec_reg;
                        if (expected_reg == LAST_SLOT) begin
                            state_next = ST_COMMIT;
                        end else begin
                            expected_next = expected_reg + 2'd1;
                        end
                    end else begin
                        anode_err_next = 1'b1;
                        state_next     = ST_SYNC;
                    end
                end
            end
            ST_COMMIT: begin
                // The completed frame is always published; a slot-0 accept
                // arriving in this same cycle starts the next frame directly.
                digit_next       = shadow_digit_reg;
                dp_next          = shadow_dp_reg;
                frame_valid_next = 1'b1;
                expected_next    = 2'd0;
                state_next       = ST_COLLECT;
                if (illegal_edge) begin
                    anode_err_next = 1'b1;
                    state_next     = ST_SYNC;
                end else if (accept) begin
                    if (slot == 2'd0) begin
                        shadow_digit_next[0] = glyph_nibble;
                        shadow_dp_next[0]    = ~dec_reg;
                        expected_next        = 2'd1;
                    end else begin
                        anode_err_next = 1'b1;
                        state_next     = ST_SYNC;
                    end
                end
            end
            default: begin
                state_next = ST_SYNC;
            end
        endcase
    end

    // FSM, shadow frame and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_SYNC;
            expected_reg    <= 2'd0;
            shadow_dp_reg   <= 4'b0000;
            dp_reg          <= 4'b0000;
            frame_valid_reg <= 1'b0;
            seg_err_reg     <= 1'b0;
            anode_err_reg   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_digit_reg[i] <= CODE_BLANK;
                digit_reg[i]        <= CODE_BLANK;
            end
        end else begin
            state_reg        <= state_next;
            expected_reg     <= expected_next;
            shadow_digit_reg <= shadow_digit_next;
            shadow_dp_reg    <= shadow_dp_next;
            digit_reg        <= digit_next;
            dp_reg           <= dp_next;
            frame_valid_reg  <= frame_valid_next;
            seg_err_reg      <= seg_err_next;
            anode_err_reg    <= anode_err_next;
        end
    end

    assign bus.digit0      = digit_reg[0];
    assign bus.digit1      = digit_reg[1];
    assign bus.digit2      = digit_reg[2];
    assign bus.digit3      = digit_reg[3];
    assign bus.dp          = dp_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.seg_err     = seg_err_reg;
    assign bus.anode_err   = anode_err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives scan patterns on the negative
// edge, checks outputs between edges against hand-computed values.
module tb_seg_scan_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   num_checks = 0;
    int   num_errors = 0;
    int   fv_count = 0;
    int   ae_count = 0;
    int   fv_base, ae_base;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .SETTLE_CYCLES (4),
        .DIGITS        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled midway between rising edges
    always @(negedge clk) begin
        if (bus.frame_valid) fv_count++;
        if (bus.anode_err)   ae_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("check %-16s = %0h ok", tag, got);
        end
    endtask

    task automatic idle(input int n);
        bus.anode_active = 4'b1111;
        bus.segments     = 7'h7F;
        bus.decimal      = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_slot(input int k, input logic [6:0] seg, input logic lit, input int n);
        logic [3:0] one;
        one = 4'b0001 << k;
        bus.anode_active = ~one;
        bus.segments     = seg;
        bus.decimal      = ~lit;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                        input logic [6:0] g3, input logic [3:0] dpm, input int n, input int gapn);
        drive_slot(0, g0, dpm[0], n); if (gapn > 0) idle(gapn);
        drive_slot(1, g1, dpm[1], n); if (gapn > 0) idle(gapn);
        drive_slot(2, g2, dpm[2], n); if (gapn > 0) idle(gapn);
        drive_slot(3, g3, dpm[3], n); if (gapn > 0) idle(gapn);
    endtask

    task automatic pulse_reset();
        bus.anode_active = 4'b1111;
        bus.segments     = 7'h7F;
        bus.decimal      = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Let in-flight pulses land and step clear of the counter sampling point
    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
        fv_base = fv_base; // no-op keeps bases untouched
    endtask

    task automatic snapshot();
        #1;
        fv_base = fv_count;
        ae_base = ae_count;
    endtask

    function automatic logic [15:0] digits_now();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    initial begin
        bus.anode_active = 4'b1111;
        bus.segments     = 7'h7F;
        bus.decimal      = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_digits", 32'(digits_now()), 32'hFFFF);
        check("rst_dp", 32'(bus.dp), 32'h0);
        check("rst_fv", 32'(bus.frame_valid), 32'h0);
        check("rst_seg_err", 32'(bus.seg_err), 32'h0);
        check("rst_anode_err", 32'(bus.anode_err), 32'h0);

        // Digits 1,2,4,5 with dp on slot 1; exact commit latency on slot 3
        snapshot();
        drive_slot(0, 7'b1001111, 1'b0, 8);
        drive_slot(1, 7'b0010010, 1'b1, 8);
        drive_slot(2, 7'b1001100, 1'b0, 8);
        bus.anode_active = 4'b0111;
        bus.segments     = 7'b0100100;
        bus.decimal      = 1'b1;
        repeat (5) @(negedge clk);
        check("lat_before", 32'(bus.frame_valid), 32'h0);
        @(negedge clk);
        check("lat_pulse", 32'(bus.frame_valid), 32'h1);
        check("scan_digits", 32'(digits_now()), 32'h5421);
        check("scan_dp", 32'(bus.dp), 32'h2);
        @(negedge clk);
        check("fv_one_cycle", 32'(bus.frame_valid), 32'h0);
        @(negedge clk);
        idle(2);
        settle();
        check("scan_fv_count", 32'(fv_count - fv_base), 32'd1);
        check("scan_no_ae", 32'(ae_count - ae_base), 32'd0);
        check("scan_seg_err", 32'(bus.seg_err), 32'h0);

        // Slots held one sample short of settling never commit
        pulse_reset();
        snapshot();
        scan(7'b1001111, 7'b0010010, 7'b1001100, 7'b0100100, 4'b0010, 3, 0);
        idle(4);
        settle();
        check("short_fv_count", 32'(fv_count - fv_base), 32'd0);
        check("short_digits", 32'(digits_now()), 32'hFFFF);

        // Out-of-order 0,1,3 flags an error and commits nothing
        snapshot();
        drive_slot(0, 7'b0001111, 1'b0, 8);
        drive_slot(1, 7'b0000000, 1'b0, 8);
        drive_slot(3, 7'b0000100, 1'b0, 8);
        idle(2);
        settle();
        check("order_ae_count", 32'(ae_count - ae_base), 32'd1);
        check("order_fv_count", 32'(fv_count - fv_base), 32'd0);
        check("order_digits", 32'(digits_now()), 32'hFFFF);

        // Clean pass with blanking gaps: digits 3,6,7,8, dp on slots 0 and 3
        snapshot();
        scan(7'b0000110, 7'b0100000, 7'b0001111, 7'b0000000, 4'b1001, 8, 2);
        settle();
        check("gap_ae_count", 32'(ae_count - ae_base), 32'd0);
        check("gap_fv_count", 32'(fv_count - fv_base), 32'd1);
        check("gap_digits", 32'(digits_now()), 32'h8763);
        check("gap_dp", 32'(bus.dp), 32'h9);

        // Two anodes low: one error pulse, then back in SYNC so slots 1..3 are ignored
        snapshot();
        bus.anode_active = 4'b1100;
        bus.segments     = 7'b0000000;
        bus.decimal      = 1'b1;
        repeat (5) @(negedge clk);
        idle(2);
        drive_slot(1, 7'b1001111, 1'b0, 8);
        drive_slot(2, 7'b1001111, 1'b0, 8);
        drive_slot(3, 7'b1001111, 1'b0, 8);
        idle(2);
        settle();
        check("multi_ae_count", 32'(ae_count - ae_base), 32'd1);
        check("multi_fv_count", 32'(fv_count - fv_base), 32'd0);
        check("multi_digits", 32'(digits_now()), 32'h8763);

        // Hex letter "A" on slot 2, blank on slot 3
        snapshot();
        scan(7'b0000001, 7'b0000100, 7'b0001000, 7'b1111111, 4'b0000, 8, 1);
        settle();
        check("hex_fv_count", 32'(fv_count - fv_base), 32'd1);
`ifdef SEG_DEC_HEX_EN
        check("hex_digits", 32'(digits_now()), 32'hFA90);
        check("hex_seg_err", 32'(bus.seg_err), 32'h0);
`else
        check("hex_digits", 32'(digits_now()), 32'hFE90);
        check("hex_seg_err", 32'(bus.seg_err), 32'h1);
`endif
        check("hex_dp", 32'(bus.dp), 32'h0);

        // Reset after slots 0,1 discards the partial frame
        drive_slot(0, 7'b1001111, 1'b1, 8);
        drive_slot(1, 7'b0010010, 1'b0, 8);
        pulse_reset();
        #1;
        check("mid_rst_digits", 32'(digits_now()), 32'hFFFF);
        check("mid_rst_dp", 32'(bus.dp), 32'h0);
        check("mid_rst_seg_err", 32'(bus.seg_err), 32'h0);
        snapshot();
        drive_slot(2, 7'b1001100, 1'b0, 8);
        drive_slot(3, 7'b0100100, 1'b0, 8);
        idle(2);
        settle();
        check("tail_fv_count", 32'(fv_count - fv_base), 32'd0);
        check("tail_digits", 32'(digits_now()), 32'hFFFF);

        // A full pass after reset commits digits 5,6,7,8
        snapshot();
        scan(7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 4'b0100, 8, 0);
        idle(2);
        settle();
        check("post_fv_count", 32'(fv_count - fv_base), 32'd1);
        check("post_digits", 32'(digits_now()), 32'h8765);
        check("post_dp", 32'(bus.dp), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
